// File: rtl/serial_subtractor_2b.sv
// serial_subtractor_2b: multi-cycle unsigned subtractor, diff = a - b,
// computed two bits per clock by adding a, ~b and a carry that starts at 1.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a/b present
//   in_ready   block can accept operands (IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   out_valid  diff/borrow valid (DONE)
//   out_ready  consumer accepts result
//   diff       (a - b) mod 2^WIDTH
//   borrow     1 when a < b
module serial_subtractor_2b #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  // Reject odd or too-small widths at elaboration.
  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("serial_subtractor_2b: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Bit offset of the current slice and its 2-bit add of a + ~b + carry.
  logic [CW:0]     idx;
  logic [1:0]      nb;
  logic [2:0]      sum;
  logic            last;

  always_comb begin
    idx  = {cnt, 1'b0};
    nb   = ~b_q[idx +: 2];
    sum  = 3'(a_q[idx +: 2]) + 3'(nb) + 3'(carry);
    last = (cnt == CW'(SLICES - 1));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            cnt      <= '0;
            carry    <= 1'b1;   // +1 of the two's complement of b
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          diff[idx +: 2] <= sum[1:0];
          carry          <= sum[2];
          cnt            <= cnt + CW'(1);
          if (last) begin
            // No carry out of the top slice means the subtraction underflowed.
            borrow    <= ~sum[2];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_2b.sv
// tb_serial_subtractor_2b: directed and random checks of serial_subtractor_2b
// (WIDTH=8): reset state, latency, arithmetic corners, backpressure,
// mid-operation reset and an in-order random regression.
module tb_serial_subtractor_2b;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow;

  int checks;
  int errors;

  serial_subtractor_2b #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Full transaction: accept, exact latency, optional stall, handshake.
  task automatic run_txn(input logic [7:0] op_a, input logic [7:0] op_b, input int stall);
    logic [8:0] m;
    m = {1'b0, op_a} - {1'b0, op_b};
    wait_ready();
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = 8'hAA;            // later operand changes must not matter
    b        = 8'h55;
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_out_valid", 32'(out_valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("latency_out_valid", 32'(out_valid), (c == 4) ? 32'd1 : 32'd0);
      check("calc_in_ready", 32'(in_ready), 32'd0);
    end
    for (int s = 0; s < stall; s++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_diff", 32'(diff), 32'(m[7:0]));
      check("stall_borrow", 32'(borrow), 32'(m[8]));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = s[0];
      a        = 8'h11;
      b        = 8'h22;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("result_diff", 32'(diff), 32'(m[7:0]));
    check("result_borrow", 32'(borrow), 32'(m[8]));
    check("result_out_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_diff_hold", 32'(diff), 32'(m[7:0]));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [8:0] m;
    logic       got;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    step();
    step();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    step();

    // Basic, underflow/wrap and equal-operand corners.
    run_txn(8'h5A, 8'h23, 0);   // 0x37, borrow 0
    run_txn(8'h10, 8'h20, 0);   // 0xF0, borrow 1
    run_txn(8'h00, 8'h01, 0);   // 0xFF, borrow 1
    run_txn(8'hFF, 8'hFF, 0);   // 0x00, borrow 0
    // Backpressure with ignored in_valid pulses.
    run_txn(8'hC3, 8'h41, 10);  // 0x82, borrow 0
    check("bp_const_diff", 32'(diff), 32'h82);

    // Reset in the second CALC cycle.
    wait_ready();
    a        = 8'h80;
    b        = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    run_txn(8'h09, 8'h04, 0);   // 0x05, borrow 0
    check("after_rst_diff", 32'(diff), 32'h05);

    // Random regression with random out_ready; stops at the first mismatch.
    for (int t = 0; t < 50; t++) begin
      int err0;
      err0 = errors;
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      m    = {1'b0, ra} - {1'b0, rb};
      wait_ready();
      a        = ra;
      b        = rb;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      got      = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("rand_result", {23'd0, borrow, diff}, {23'd0, m});
          got = 1'b1;
        end
        step();
      end
      out_ready = 1'b0;
      check("rand_got_result", 32'(got), 32'd1);
      check("rand_single_result", 32'(out_valid), 32'd0);
      if (errors != err0) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_2b.md
Name: serial_subtractor_2b

Overview:
- Multi-cycle unsigned subtractor, the inverse operation of the 2-bit adder datapath.
- Computes a - b over WIDTH bits, two bits per clock, using an internal 2-bit slice that adds a, ~b and a carry.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Used where a full-width combinational subtractor is too large and a latency of a few cycles is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be even and >= 2; otherwise elaboration fails.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/borrow valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned).

Behaviour:
- Single clock domain. Reset: rst sampled on rising clk only, active-high.
- During and after reset: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, slice counter=0, internal carry=1.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k, latch a and b, set counter=0 and carry=1 (two's-complement +1), go to CALC.
  - CALC: in_ready=0. Each edge processes slice i = counter: {c, d[2i+1:2i]} = a[2i+1:2i] + ~b[2i+1:2i] + carry. d is written into the diff register and carry<=c. Counter increments.
  - CALC exit: on the edge that processes slice WIDTH/2-1, go to DONE, set out_valid=1 and borrow = ~c (final carry inverted).
  - DONE: out_valid=1, in_ready=0. On out_valid&&out_ready, go to IDLE, clear out_valid, set in_ready=1 at the next edge.
- Latency: out_valid rises exactly WIDTH/2 cycles after the input-accept edge (4 cycles for WIDTH=8).
- Throughput: one result per WIDTH/2+2 cycles.
- No accept in the same cycle as the output handshake.
- in_valid, a and b are ignored outside IDLE. The latched copies are used, so operand changes during CALC have no effect.
- diff and borrow are stable while out_valid=1 (backpressure of any length).
- After the output handshake, diff and borrow hold their last value until the next CALC begins. During CALC, diff is partially updated, and consumers must qualify with out_valid.
- Arithmetic: result equals the low WIDTH bits of a - b. borrow is the unsigned underflow flag. Equal operands give diff=0, borrow=0.
- Reset mid-operation (CALC or DONE) aborts the operation. All outputs return to reset values on the next edge, and the pending result is lost.
- rst has priority over every handshake in the same cycle.
- out_ready while not out_valid has no effect.

Test Plan:
- WIDTH=8: a=0x5A, b=0x23, in_valid pulse, out_ready=1 -> out_valid exactly 4 cycles after accept, diff=0x37, borrow=0. in_ready low for the 4 CALC cycles plus the DONE cycle.
- Underflow and wrap (separate transactions): a=0x10, b=0x20 -> diff=0xF0, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=0xFF, b=0xFF -> diff=0x00, borrow=0.
- Backpressure: a=0xC3, b=0x41, out_ready=0 for 10 cycles.
  - out_valid stays 1 and diff=0x82, borrow=0 stay constant.
  - in_valid pulses with other operands during this time are not accepted (in_ready=0).
  - When out_ready=1, the handshake completes and in_ready returns 1 the next cycle.
- Reset mid-CALC: accept a=0x80, b=0x01, assert rst on the 2nd CALC cycle -> next edge in_ready=1, out_valid=0, diff=0, borrow=0. A new transaction a=0x09, b=0x04 then yields diff=0x05, borrow=0.
- Randomised regression: 50 random a/b pairs, out_ready randomly toggled -> every {borrow,diff} equals the 9-bit model result {a<b, (a-b) mod 256}. Each accepted input produces exactly one result, in order. The first mismatch stops the run with a FAIL report.
